// File: rtl/sb_plane_ctrl_if.sv
// Bus-side request/response bundle for sb_plane_ctrl.
// The master drives requests, and the slave returns ready and read data.
interface sb_plane_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                  req_i;
  logic                  write_enable_i;
  logic [DATA_W/8-1:0]   mem_be_i;
  logic [31:0]           addr_i;
  logic [DATA_W-1:0]     write_data_i;
  logic                  ready_o;
  logic                  rvalid_o;
  logic [DATA_W-1:0]     read_data_o;

  modport master (
    output req_i, write_enable_i, mem_be_i, addr_i, write_data_i,
    input  ready_o, rvalid_o, read_data_o
  );

  modport slave (
    input  req_i, write_enable_i, mem_be_i, addr_i, write_data_i,
    output ready_o, rvalid_o, read_data_o
  );
endinterface

// File: rtl/sb_plane_ctrl.sv
// Multi-plane word memory with a bus port, a never-stalled display read port
// and a fill engine that writes one word per cycle into a mask of planes.
module sb_plane_ctrl #(
  parameter int NUM_PLANES  = 3,
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_W      = 32,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sb_plane_ctrl_if.slave    bus,
  input  logic              disp_req_i,
  input  logic [2:0]        disp_plane_i,
  input  logic [IDX_W-1:0]  disp_addr_i,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              fill_busy_o,
  output logic              irq_o
);
  localparam int BE_W = DATA_W / 8;
  localparam int PL_W = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
  localparam logic [3:0] NP4 = 4'(NUM_PLANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_count;
  logic [NUM_PLANES-1:0]   r_mask;
  logic [DATA_W-1:0]       r_fillValue;
  logic [DATA_W-1:0]       r_fillLatched;
  logic                    r_done;
  logic                    r_err;
  logic                    r_rvalid;
  logic [DATA_W-1:0]       r_rdata;
  logic [DATA_W-1:0]       r_dispRdata;
  logic [DATA_W-1:0]       r_mem [NUM_PLANES][DEPTH_WORDS];

  logic [3:0]              w_plane;
  logic [PL_W-1:0]         w_planeIdx;
  logic [PL_W-1:0]         w_dispIdx;
  logic [IDX_W-1:0]        w_word;
  logic [1:0]              w_regOff;
  logic                    w_isPlane, w_isCtrl, w_unmapped;
  logic                    w_busy, w_ready, w_acc, w_wr, w_rd;
  logic                    w_ctrlWr, w_start, w_doneSet;
  logic [NUM_PLANES-1:0]   w_startMask;
  logic [DATA_W-1:0]       w_status, w_rdMux;
  logic                    w_unused;

  assign w_plane     = bus.addr_i[19:16];
  assign w_planeIdx  = bus.addr_i[16 +: PL_W];
  assign w_dispIdx   = disp_plane_i[PL_W-1:0];
  assign w_word      = bus.addr_i[IDX_W+1:2];
  assign w_regOff    = bus.addr_i[3:2];
  assign w_isPlane   = (w_plane < NP4);
  assign w_isCtrl    = (w_plane == 4'hF);
  assign w_unmapped  = !w_isPlane && !w_isCtrl;
  assign w_busy      = (r_state == FILL);
  assign w_ready     = rst_i && !(w_busy && w_isPlane);
  assign w_acc       = bus.req_i && w_ready;
  assign w_wr        = w_acc && bus.write_enable_i;
  assign w_rd        = w_acc && !bus.write_enable_i;
  assign w_ctrlWr    = w_wr && w_isCtrl && (w_regOff == 2'd0);
  assign w_startMask = bus.write_data_i[8 +: NUM_PLANES];
  assign w_start     = w_ctrlWr && bus.write_data_i[0];
  // A zero-mask start completes immediately; a real fill completes on its last word.
  assign w_doneSet   = (w_busy && (r_count == LAST)) ||
                       (!w_busy && w_start && (w_startMask == '0));
  assign w_unused    = ^bus.addr_i;

  assign bus.ready_o     = w_ready;
  assign bus.rvalid_o    = r_rvalid;
  assign bus.read_data_o = r_rdata;
  assign disp_rdata_o    = r_dispRdata;
  assign fill_busy_o     = w_busy;
  assign irq_o           = r_done;

  always_comb begin
    w_status      = '0;
    w_status[2:0] = {r_err, r_done, w_busy};
    w_rdMux       = '0;
    if (w_isPlane) begin
      w_rdMux = r_mem[w_planeIdx][w_word];
    end else if (w_isCtrl) begin
      case (w_regOff)
        2'd1:    w_rdMux = r_fillValue;
        2'd2:    w_rdMux = w_status;
        default: w_rdMux = '0;
      endcase
    end
  end

  // Plane storage is deliberately left out of reset; writes stop while rst_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_busy) begin
      for (int p = 0; p < NUM_PLANES; p++) begin
        if (r_mask[p]) r_mem[p][r_count] <= r_fillLatched;
      end
    end
    if (w_wr && w_isPlane) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.mem_be_i[b]) r_mem[w_planeIdx][w_word][8*b +: 8] <= bus.write_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_mask        <= '0;
      r_fillValue   <= '0;
      r_fillLatched <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_dispRdata   <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdMux;

      if (disp_req_i) begin
        if ({1'b0, disp_plane_i} < NP4) r_dispRdata <= r_mem[w_dispIdx][disp_addr_i];
        else                            r_dispRdata <= '0;
      end

      if (w_wr && w_isCtrl && (w_regOff == 2'd1)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (bus.mem_be_i[b]) r_fillValue[8*b +: 8] <= bus.write_data_i[8*b +: 8];
        end
      end

      if (w_acc && w_unmapped)                r_err <= 1'b1;
      else if (w_ctrlWr && bus.write_data_i[2]) r_err <= 1'b0;

      if (w_doneSet)                          r_done <= 1'b1;
      else if (w_ctrlWr && bus.write_data_i[1]) r_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_start && (w_startMask != '0)) begin
            r_state       <= FILL;
            r_mask        <= w_startMask;
            r_fillLatched <= r_fillValue;
            r_count       <= '0;
          end
        end
        FILL: begin
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_state <= IDLE;
            r_count <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_plane_ctrl.sv
// Directed, table-driven bench for sb_plane_ctrl with a shadow model of the planes
// used for fill, display-port and reset-abort checks.
module tb_sb_plane_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        disp_req_i;
  logic [2:0]  disp_plane_i;
  logic [9:0]  disp_addr_i;
  logic [31:0] disp_rdata_o;
  logic        fill_busy_o;
  logic        irq_o;

  sb_plane_ctrl_if #(.DATA_W(32)) bus ();

  sb_plane_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .disp_req_i   (disp_req_i),
    .disp_plane_i (disp_plane_i),
    .disp_addr_i  (disp_addr_i),
    .disp_rdata_o (disp_rdata_o),
    .fill_busy_o  (fill_busy_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expRvalid;
    logic [31:0] expRdata;
  } vec_t;

  vec_t        vecs [24];
  logic [31:0] shadow [3][1024];
  int          vecCount  = 0;
  int          missCount = 0;

  function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rv, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.expRvalid = rv; v.expRdata = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] data);
    bus.req_i          = 1'b1;
    bus.write_enable_i = we;
    bus.mem_be_i       = be;
    bus.addr_i         = addr;
    bus.write_data_i   = data;
  endtask

  task automatic busIdle();
    bus.req_i          = 1'b0;
    bus.write_enable_i = 1'b0;
    bus.mem_be_i       = 4'h0;
    bus.addr_i         = 32'h0;
    bus.write_data_i   = 32'h0;
  endtask

  task automatic busCycle(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] data);
    applyStimulus(we, be, addr, data);
    @(posedge clk_i); #1;
    busIdle();
  endtask

  task automatic checkPlanes(input string tag);
    int bad;
    for (int p = 0; p < 3; p++) begin
      bad = 0;
      for (int w = 0; w < 1024; w++) begin
        applyStimulus(1'b0, 4'hF, (32'(p) << 16) | (32'(w) << 2), 32'h0);
        @(posedge clk_i); #1;
        if (bus.read_data_o !== shadow[p][w]) bad++;
      end
      busIdle();
      checkOutput($sformatf("%s_plane%0d_bad_words", tag, p), 32'(bad), 32'd0);
    end
  endtask

  initial begin
    int n;
    int dp;
    int da;
    int dispBad;
    logic [31:0] expDisp;

    busIdle();
    rst_i        = 1'b0;
    disp_req_i   = 1'b1;
    disp_plane_i = 3'd0;
    disp_addr_i  = 10'd0;
    for (int b = 0; b < 1024; b++) for (int p = 0; p < 3; p++) shadow[p][b] = 32'h0;

    // Reset: outputs cleared and no request accepted.
    repeat (3) @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 4'hF, 32'h0000_0000, 32'h0);
    #1;
    checkOutput("reset_ready", 32'(bus.ready_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("reset_rvalid", 32'(bus.rvalid_o), 32'd0);
    checkOutput("reset_rdata", bus.read_data_o, 32'h0);
    checkOutput("reset_disp", disp_rdata_o, 32'h0);
    checkOutput("reset_busy", 32'(fill_busy_o), 32'd0);
    checkOutput("reset_irq", 32'(irq_o), 32'd0);
    busIdle();
    disp_req_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Zero fill of all planes establishes a known memory image.
    busCycle(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0701);
    n = 0;
    while (fill_busy_o === 1'b1 && n < 2000) begin
      @(posedge clk_i); #1;
      n++;
    end
    checkOutput("zero_fill_cycles", 32'(n), 32'd1024);
    checkOutput("zero_fill_irq", 32'(irq_o), 32'd1);

    vecs[0]  = mk(1, 4'h3, 32'h0001_0008, 32'hA5A5_A5A5, 0, 32'h0000_0000);
    vecs[1]  = mk(0, 4'hF, 32'h0001_0008, 32'h0,         1, 32'h0000_A5A5);
    vecs[2]  = mk(1, 4'hC, 32'h0001_0008, 32'h1234_5678, 0, 32'h0000_A5A5);
    vecs[3]  = mk(0, 4'hF, 32'h0001_0008, 32'h0,         1, 32'h1234_A5A5);
    vecs[4]  = mk(1, 4'hF, 32'h000F_0004, 32'hDEAD_BEEF, 0, 32'h1234_A5A5);
    vecs[5]  = mk(0, 4'hF, 32'h000F_0004, 32'h0,         1, 32'hDEAD_BEEF);
    vecs[6]  = mk(1, 4'h1, 32'h000F_0004, 32'h0000_0011, 0, 32'hDEAD_BEEF);
    vecs[7]  = mk(0, 4'hF, 32'h000F_0004, 32'h0,         1, 32'hDEAD_BE11);
    vecs[8]  = mk(0, 4'hF, 32'h000F_0000, 32'h0,         1, 32'h0000_0000);
    vecs[9]  = mk(1, 4'hF, 32'h000F_000C, 32'hFFFF_FFFF, 0, 32'h0000_0000);
    vecs[10] = mk(0, 4'hF, 32'h000F_000C, 32'h0,         1, 32'h0000_0000);
    vecs[11] = mk(0, 4'hF, 32'h000F_0008, 32'h0,         1, 32'h0000_0002);
    vecs[12] = mk(1, 4'hF, 32'h0002_0FFC, 32'hCAFE_F00D, 0, 32'h0000_0002);
    vecs[13] = mk(0, 4'hF, 32'h0002_0FFF, 32'h0,         1, 32'hCAFE_F00D);
    vecs[14] = mk(0, 4'hF, 32'h0000_0FFC, 32'h0,         1, 32'h0000_0000);
    vecs[15] = mk(0, 4'hF, 32'h0005_0000, 32'h0,         1, 32'h0000_0000);
    vecs[16] = mk(0, 4'hF, 32'h000F_0008, 32'h0,         1, 32'h0000_0006);
    vecs[17] = mk(1, 4'h0, 32'h000F_0000, 32'h0000_0004, 0, 32'h0000_0006);
    vecs[18] = mk(0, 4'hF, 32'h000F_0008, 32'h0,         1, 32'h0000_0002);
    vecs[19] = mk(1, 4'hF, 32'h0003_0000, 32'h7777_7777, 0, 32'h0000_0002);
    vecs[20] = mk(0, 4'hF, 32'h0003_0000, 32'h0,         1, 32'h0000_0000);
    vecs[21] = mk(0, 4'hF, 32'h000F_0008, 32'h0,         1, 32'h0000_0006);
    vecs[22] = mk(1, 4'hF, 32'h000F_0000, 32'h0000_0006, 0, 32'h0000_0006);
    vecs[23] = mk(0, 4'hF, 32'h000F_0008, 32'h0,         1, 32'h0000_0000);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), 32'(bus.ready_o), 32'd1);
      @(posedge clk_i); #1;
      busIdle();
      checkOutput($sformatf("vec%0d_rvalid", i), 32'(bus.rvalid_o), 32'(vecs[i].expRvalid));
      checkOutput($sformatf("vec%0d_rdata", i), bus.read_data_o, vecs[i].expRdata);
      if (vecs[i].we && vecs[i].addr[19:16] < 4'd3) begin
        for (int b = 0; b < 4; b++)
          if (vecs[i].be[b])
            shadow[vecs[i].addr[17:16]][vecs[i].addr[11:2]][8*b +: 8] = vecs[i].wdata[8*b +: 8];
      end
    end
    checkOutput("irq_after_clear", 32'(irq_o), 32'd0);

    // Display port holds its value while disp_req_i is low.
    disp_req_i = 1'b1; disp_plane_i = 3'd1; disp_addr_i = 10'd2;
    @(posedge clk_i); #1;
    checkOutput("disp_read", disp_rdata_o, 32'h1234_A5A5);
    disp_req_i = 1'b0;
    busCycle(1'b1, 4'hF, 32'h0001_0008, 32'h0);
    shadow[1][2] = 32'h0;
    @(posedge clk_i); #1;
    checkOutput("disp_hold", disp_rdata_o, 32'h1234_A5A5);
    disp_req_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("disp_reread", disp_rdata_o, 32'h0);

    // Masked fill of planes 0 and 2 with bus traffic and display reads every cycle.
    busCycle(1'b1, 4'hF, 32'h000F_0004, 32'h1122_3344);
    busCycle(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0501);
    n = 0;
    dispBad = 0;
    while (fill_busy_o === 1'b1 && n < 2000) begin
      busIdle();
      dp = n % 4;
      da = ((n % 2) == 1) ? (n - 1) % 1024 : n % 1024;
      disp_req_i = 1'b1; disp_plane_i = 3'(dp); disp_addr_i = 10'(da);
      expDisp = (dp < 3) ? shadow[dp][da] : 32'h0;
      if (n == 3)  applyStimulus(1'b0, 4'hF, 32'h000F_0008, 32'h0);
      if (n == 10) applyStimulus(1'b1, 4'hF, 32'h000F_0004, 32'h9999_9999);
      if (n == 20) applyStimulus(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0701);
      if (n == 30) begin
        applyStimulus(1'b0, 4'hF, 32'h0001_0008, 32'h0);
        #1;
        checkOutput("plane_ready_during_fill", 32'(bus.ready_o), 32'd0);
      end
      @(posedge clk_i); #1;
      if (n < 1024) begin
        shadow[0][n] = 32'h1122_3344;
        shadow[2][n] = 32'h1122_3344;
      end
      if (disp_rdata_o !== expDisp) dispBad++;
      if (n == 3) begin
        checkOutput("status_rvalid_during_fill", 32'(bus.rvalid_o), 32'd1);
        checkOutput("status_during_fill", bus.read_data_o, 32'h0000_0001);
      end
      if (n == 30) checkOutput("plane_read_stalled", 32'(bus.rvalid_o), 32'd0);
      n++;
    end
    busIdle();
    disp_req_i = 1'b0;
    checkOutput("fill_busy_cycles", 32'(n), 32'd1024);
    checkOutput("disp_during_fill_bad", 32'(dispBad), 32'd0);
    checkOutput("fill_irq", 32'(irq_o), 32'd1);
    busCycle(1'b0, 4'hF, 32'h000F_0008, 32'h0);
    checkOutput("status_after_fill", bus.read_data_o, 32'h0000_0002);
    busCycle(1'b0, 4'hF, 32'h000F_0004, 32'h0);
    checkOutput("fill_value_after_fill", bus.read_data_o, 32'h9999_9999);
    checkPlanes("fill");

    // Zero effective mask: no fill, done set; set wins over a simultaneous clear.
    busCycle(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0002);
    checkOutput("done_cleared", 32'(irq_o), 32'd0);
    busCycle(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0801);
    checkOutput("zero_mask_busy", 32'(fill_busy_o), 32'd0);
    checkOutput("zero_mask_done", 32'(irq_o), 32'd1);
    busCycle(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0002);
    busCycle(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0803);
    checkOutput("done_set_wins", 32'(irq_o), 32'd1);

    // Reset during fill cycle 500 aborts it, leaving words 500.. untouched.
    busCycle(1'b1, 4'hF, 32'h000F_0004, 32'h55AA_55AA);
    busCycle(1'b1, 4'hF, 32'h000F_0000, 32'h0000_0101);
    for (int k = 0; k < 500; k++) begin
      @(posedge clk_i); #1;
      shadow[0][k] = 32'h55AA_55AA;
    end
    checkOutput("busy_before_abort", 32'(fill_busy_o), 32'd1);
    rst_i = 1'b0;
    applyStimulus(1'b0, 4'hF, 32'h000F_0008, 32'h0);
    #1;
    checkOutput("abort_ready", 32'(bus.ready_o), 32'd0);
    @(posedge clk_i); #1;
    busIdle();
    checkOutput("abort_busy", 32'(fill_busy_o), 32'd0);
    checkOutput("abort_irq", 32'(irq_o), 32'd0);
    checkOutput("abort_rvalid", 32'(bus.rvalid_o), 32'd0);
    checkOutput("abort_rdata", bus.read_data_o, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    busCycle(1'b0, 4'hF, 32'h000F_0008, 32'h0);
    checkOutput("abort_status", bus.read_data_o, 32'h0);
    busCycle(1'b0, 4'hF, 32'h000F_0004, 32'h0);
    checkOutput("abort_fill_value", bus.read_data_o, 32'h0);
    checkPlanes("abort");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
